// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: ALU results win, LSU results queue in a FIFO,
// with a starvation limiter. Define WB_HAZARD_EN for per-register busy tracking.
module writeback_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic        alu_stall,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        wr_ena,
    output logic [31:0] busy_mask
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1) + 1;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    wb_entry_t     mem [DEPTH];
    logic [PW-1:0] head, tail;
    logic [PW:0]   count;
    logic [3:0]    starve, starve_next;
    logic          empty, full, push, pop, alu_win;

    assign empty     = (count == '0);
    assign full      = (count == (PW+1)'(DEPTH));
    // Ready depends only on registered occupancy; a same-cycle pop does not help.
    assign lsu_ready = !full;
    assign push      = lsu_valid && !full && (lsu_rd != 5'd0);
    assign alu_win   = alu_valid && (alu_rd != 5'd0);
    assign pop       = !alu_win && !empty;

    always_comb begin
        starve_next = starve;
        if (empty || pop)
            starve_next = '0;
        else if (alu_win && starve != 4'(STARVE_MAX))
            starve_next = starve + 4'd1;
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[tail] <= '{rd: lsu_rd, data: lsu_data};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            starve    <= '0;
            alu_stall <= 1'b0;
            wr_ena    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: ;
            endcase
            starve <= starve_next;
            // One-cycle pulse; the stalled cycle normally pops and clears the counter.
            alu_stall <= (starve_next == 4'(STARVE_MAX)) && !alu_stall;
            if (alu_win) begin
                wr_ena  <= 1'b1;
                wr_addr <= alu_rd;
                wr_data <= alu_data;
            end else if (pop) begin
                wr_ena  <= 1'b1;
                wr_addr <= mem[head].rd;
                wr_data <= mem[head].data;
            end else begin
                wr_ena  <= 1'b0;
            end
        end
    end

`ifdef WB_HAZARD_EN
    logic [CW-1:0] pend [32];
    logic          wr_lsu;

    // A register stays busy until the edge after its last LSU write leaves the output flop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_lsu <= 1'b0;
            for (int r = 0; r < 32; r++) pend[r] <= '0;
        end else begin
            wr_lsu <= pop;
            for (int r = 0; r < 32; r++)
                pend[r] <= pend[r] + CW'(push && lsu_rd == 5'(r))
                                   - CW'(wr_lsu && wr_addr == 5'(r));
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int r = 0; r < 32; r++) busy_mask[r] = (pend[r] != '0);
    end
`else
    assign busy_mask = '0;
`endif

    a_no_alu_during_stall: assert property (
        @(posedge clock) disable iff (!reset_n) !(alu_valid && alu_stall));

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus a per-path ordering scoreboard.
module tb_writeback_arbiter;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        alu_valid, lsu_valid, lsu_ready, alu_stall, wr_ena;
    logic [4:0]  alu_rd, lsu_rd, wr_addr;
    logic [31:0] alu_data, lsu_data, wr_data, busy_mask;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

`ifdef WB_HAZARD_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    int  compared   = 0;
    int  mismatched = 0;
    wb_t lsu_q[$];
    wb_t alu_exp;
    bit  alu_pend = 1'b0;

    writeback_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .alu_stall(alu_stall), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ena(wr_ena),
        .busy_mask(busy_mask)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    endtask

    // ALU writes must appear exactly one cycle later; LSU writes in acceptance order.
    task automatic monitor();
        wb_t e;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                lsu_q.delete();
                alu_pend = 1'b0;
            end else begin
                if (alu_pend) begin
                    compared++;
                    if (wr_ena !== 1'b1 || wr_addr !== alu_exp.rd || wr_data !== alu_exp.data) begin
                        mismatched++;
                        $display("FAIL sb_alu: got ena=%b addr=%0d data=%h, want ena=1 addr=%0d data=%h",
                                 wr_ena, wr_addr, wr_data, alu_exp.rd, alu_exp.data);
                    end
                end else if (wr_ena === 1'b1) begin
                    compared++;
                    if (lsu_q.size() == 0) begin
                        mismatched++;
                        $display("FAIL sb_lsu_unexpected: got addr=%0d data=%h, want no write", wr_addr, wr_data);
                    end else begin
                        e = lsu_q.pop_front();
                        if (wr_addr !== e.rd || wr_data !== e.data) begin
                            mismatched++;
                            $display("FAIL sb_lsu: got addr=%0d data=%h, want addr=%0d data=%h",
                                     wr_addr, wr_data, e.rd, e.data);
                        end
                    end
                end
                alu_pend = alu_valid && (alu_rd != 5'd0);
                alu_exp  = '{rd: alu_rd, data: alu_data};
                if (lsu_valid && lsu_ready && lsu_rd != 5'd0)
                    lsu_q.push_back('{rd: lsu_rd, data: lsu_data});
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        #12 reset_n = 1'b1;
        step();
        compared++;
        if (wr_ena !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_wr: got ena=%b addr=%0d data=%h, want 0/0/0", wr_ena, wr_addr, wr_data);
        end
        compared++;
        if (lsu_ready !== 1'b1 || alu_stall !== 1'b0 || busy_mask !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_ctl: got ready=%b stall=%b busy=%h, want 1/0/0", lsu_ready, alu_stall, busy_mask);
        end
    endtask

    task automatic test_alu();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        compared++;
        if (wr_ena !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF) begin
            mismatched++;
            $display("FAIL alu_write: got ena=%b addr=%0d data=%h, want 1/5/deadbeef", wr_ena, wr_addr, wr_data);
        end
        alu_rd = 5'd0; alu_data = 32'h1234;
        step();
        compared++;
        if (wr_ena !== 1'b0 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF) begin
            mismatched++;
            $display("FAIL alu_x0: got ena=%b addr=%0d data=%h, want 0/5/deadbeef (held)", wr_ena, wr_addr, wr_data);
        end
        idle();
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h5555;
        step();
        idle();
        step();
        compared++;
        if (wr_ena !== 1'b0 || lsu_q.size() != 0) begin
            mismatched++;
            $display("FAIL lsu_x0: got ena=%b queued=%0d, want 0/0", wr_ena, lsu_q.size());
        end
    endtask

    task automatic test_lsu_latency();
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h0000_0077;
        step();
        idle();
        compared++;
        if (wr_ena !== 1'b0 || busy_mask[7] !== HZ) begin
            mismatched++;
            $display("FAIL lsu_lat_n: got ena=%b busy7=%b, want 0/%b", wr_ena, busy_mask[7], HZ);
        end
        step();
        compared++;
        if (wr_ena !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 32'h77 || busy_mask[7] !== HZ) begin
            mismatched++;
            $display("FAIL lsu_lat_n1: got ena=%b addr=%0d data=%h busy7=%b, want 1/7/77/%b",
                     wr_ena, wr_addr, wr_data, busy_mask[7], HZ);
        end
        step();
        compared++;
        if (wr_ena !== 1'b0 || busy_mask !== 32'd0) begin
            mismatched++;
            $display("FAIL lsu_lat_n2: got ena=%b busy=%h, want 0/0", wr_ena, busy_mask);
        end
    endtask

    task automatic test_starvation();
        bit exp_ready, exp_stall;
        for (int e = 1; e <= 12; e++) begin
            alu_valid = (e <= 10 && e != 6);
            alu_rd    = 5'(9 + e);
            alu_data  = 32'hA000_0000 + 32'(e);
            lsu_valid = (e <= 7);
            lsu_rd    = (e < 3) ? 5'(e) : 5'd3;
            lsu_data  = 32'h1000_0000 + 32'(lsu_rd);
            if (e <= 7) begin
                exp_ready = (e <= 2 || e == 7);
                compared++;
                if (lsu_ready !== exp_ready) begin
                    mismatched++;
                    $display("FAIL starve_ready e%0d: got %b, want %b", e, lsu_ready, exp_ready);
                end
            end
            step();
            exp_stall = (e == 5 || e == 10);
            compared++;
            if (alu_stall !== exp_stall) begin
                mismatched++;
                $display("FAIL starve_stall e%0d: got %b, want %b", e, alu_stall, exp_stall);
            end
            if (e == 6 || e == 11 || e == 12) begin
                compared++;
                if (wr_ena !== 1'b1 || wr_addr !== ((e == 6) ? 5'd1 : (e == 11) ? 5'd2 : 5'd3)) begin
                    mismatched++;
                    $display("FAIL starve_drain e%0d: got ena=%b addr=%0d", e, wr_ena, wr_addr);
                end
            end
        end
        idle();
        step();
    endtask

    task automatic test_full_pop();
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hB20;
        lsu_valid = 1'b1; lsu_rd = 5'd8;  lsu_data = 32'hC08;
        step();
        alu_rd = 5'd21; alu_data = 32'hB21;
        lsu_rd = 5'd9;  lsu_data = 32'hC09;
        step();
        alu_valid = 1'b0;
        lsu_rd = 5'd13; lsu_data = 32'hC13;
        compared++;
        if (lsu_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL full_pop_ready0: got %b, want 0", lsu_ready);
        end
        step();
        compared++;
        if (lsu_ready !== 1'b1 || wr_addr !== 5'd8) begin
            mismatched++;
            $display("FAIL full_pop_ready1: got ready=%b addr=%0d, want 1/8", lsu_ready, wr_addr);
        end
        step();
        lsu_valid = 1'b0;
        compared++;
        if (wr_addr !== 5'd9 || lsu_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL full_pop_second: got addr=%0d ready=%b, want 9/1", wr_addr, lsu_ready);
        end
        step();
        compared++;
        if (wr_ena !== 1'b1 || wr_addr !== 5'd13 || wr_data !== 32'hC13) begin
            mismatched++;
            $display("FAIL full_pop_third: got ena=%b addr=%0d data=%h, want 1/13/c13", wr_ena, wr_addr, wr_data);
        end
        step();
        compared++;
        if (wr_ena !== 1'b0 || lsu_q.size() != 0) begin
            mismatched++;
            $display("FAIL full_pop_done: got ena=%b queued=%0d, want 0/0", wr_ena, lsu_q.size());
        end
    endtask

    task automatic test_reset_mid_drain();
        alu_valid = 1'b1; alu_rd = 5'd22; alu_data = 32'hB22;
        lsu_valid = 1'b1; lsu_rd = 5'd14; lsu_data = 32'hC14;
        step();
        alu_rd = 5'd23; alu_data = 32'hB23;
        lsu_rd = 5'd15; lsu_data = 32'hC15;
        step();
        idle();
        step();
        #2 reset_n = 1'b0;
        #1;
        compared++;
        if (wr_ena !== 1'b0 || lsu_ready !== 1'b1 || busy_mask !== 32'd0 || wr_addr !== 5'd0) begin
            mismatched++;
            $display("FAIL reset_async: got ena=%b ready=%b busy=%h addr=%0d, want 0/1/0/0",
                     wr_ena, lsu_ready, busy_mask, wr_addr);
        end
        #4 reset_n = 1'b1;
        lsu_q.delete();
        for (int i = 0; i < 3; i++) begin
            step();
            compared++;
            if (wr_ena !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_stale c%0d: got ena=%b, want 0", i, wr_ena);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        fork
            monitor();
        join_none
        test_reset();
        test_alu();
        test_lsu_latency();
        test_starvation();
        test_full_pop();
        test_reset_mid_drain();
        step();
        compared++;
        if (lsu_q.size() != 0) begin
            mismatched++;
            $display("FAIL sb_leftover: got %0d pending LSU writes, want 0", lsu_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
